// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the Uart8 receiver: captures {err, byte} on each rising rx_done
// and hands entries to the consumer over a first-word-fall-through valid/ready interface.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_done,
    input  logic                  rx_err,
    input  logic [7:0]            rx_byte,
    input  logic                  capture_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_err,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] WRAP_BIT = PW'(1) << DEPTH_LOG2;

    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          done_q;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          drop;

    assign push_req = rx_done & ~done_q & capture_en;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr ^ rd_ptr) == WRAP_BIT);
    assign pop      = ~empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign out_valid = ~empty;
    assign count     = wr_ptr - rd_ptr;
    assign {out_err, out_data} = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // done_q resets high so a done level held across reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            done_q <= rx_done;
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {rx_err, rx_byte};
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the Uart8 receiver.
- Captures each completed byte, together with its framing-error status, when the receiver's done signal rises.
- Holds captured bytes in a circular FIFO and presents them to the consumer over a valid/ready interface.
- Decouples the bursty 9600-baud byte arrival from consumer logic and flags overruns.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries of 9 bits (err + byte).

Ports:
- clk  input  1  system clock (12 MHz on Alhambra).
- rst  input  1  synchronous, active-high reset.
- rx_done  input  1  Uart8 rxDone; a rising edge marks a completed byte.
- rx_err  input  1  Uart8 rxErr; sampled together with rx_byte at capture.
- rx_byte  input  8  Uart8 rxOut.
- capture_en  input  1  when low, rising edges on rx_done are ignored.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry when out_valid && out_ready.
- out_data  output  8  head byte.
- out_err  output  1  head entry's error tag.
- count  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- clear_overflow  input  1  single-cycle pulse that clears overflow.

Behaviour:
- Edge detect:
  - done_q registers rx_done every cycle.
  - push_req = rx_done & ~done_q & capture_en.
  - done_q resets to 1, so an rx_done held high through reset release never produces a push.
- Capture: on push_req, {rx_err, rx_byte} present in the same cycle is written to mem[wr_ptr].
- Pop: pop = out_valid & out_ready; rd_ptr advances on the following edge.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide (extra wrap bit).
  - full = (pointers differ only in MSB); empty = (pointers equal).
  - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
  - Pointers wrap naturally past the top index; no special case.
- Outputs:
  - out_valid = ~empty.
  - out_data and out_err = mem[rd_ptr[DEPTH_LOG2-1:0]], asynchronous read (first-word fall-through).
- Latency: a rising edge of rx_done sampled at clock edge N writes at edge N; out_valid is high from cycle N+1 when the FIFO was previously empty.
- Full without pop: push is dropped, memory and pointers are unchanged, overflow is set on the same edge.
- Full with pop in the same cycle: push is accepted; count stays at 2**DEPTH_LOG2 and the dropped-byte path is not taken.
- Empty with out_ready high: no pop and no pointer change.
- Push and pop on a non-empty, non-full FIFO: both occur and count is unchanged.
- Overflow flag:
  - Set has priority over clear_overflow in the same cycle.
  - Otherwise clear_overflow clears it on the next edge.
- Reset (including mid-operation, e.g. during a receive or with entries pending), on the next edge:
  - wr_ptr = rd_ptr = 0 and count = 0.
  - out_valid = 0 and overflow = 0.
  - done_q = 1.
  - Memory contents are not cleared; they are don't-care because out_valid = 0.
  - out_data and out_err are undefined until the first push.
- rx_err is stored per entry and is not accumulated; an errored byte occupies a slot like any other.
- No combinational path from rx_* inputs to outputs.

Test Plan:
- Reset then single byte:
  - Stimulus: hold rst 2 cycles; rx_byte=0x56, rx_err=0; rx_done 0→1 and held high 100 cycles.
  - Required: exactly one push; count=1; out_valid=1; out_data=0x56; out_err=0.
  - Then pulse out_ready 1 cycle → count=0, out_valid=0.
- Ordering and wrap:
  - Stimulus: with out_ready=0, push 0x01..0x10 (16 entries).
  - Required: count=16; overflow=0.
  - Then pop 8, push 0x11..0x18, pop all → data read back in order 0x01..0x18; final count=0.
- Overflow:
  - Stimulus: fill to 16, push 0xAA with no pop.
  - Required: overflow=1; count=16; head still 0x01.
  - Then clear_overflow pulse → overflow=0.
  - Then clear_overflow and a dropped push in the same cycle → overflow=1.
- Full with simultaneous pop/push:
  - Stimulus: at count=16, assert out_ready in the same cycle as rising rx_done with 0xBB.
  - Required: count stays 16; overflow=0; 0xBB is the last entry read.
- Error tag and enable:
  - Stimulus: push 0x56 with rx_err=1.
  - Required: out_err=1 for that entry only; the next entry with rx_err=0 gives out_err=0.
  - With capture_en=0, a rising rx_done causes no push.
- Reset mid-stream:
  - Stimulus: with count=5 and rx_done held high, assert rst 1 cycle.
  - Required: count=0; out_valid=0; overflow=0; no push on release.
  - Next 0→1 on rx_done pushes normally.
